// File: rtl/wb_timer_pkg.sv
// Shared constants and types for the multi-channel Wishbone timer.
// Build option: WB_TIMER_CAPTURE_EN enables the per-channel input capture unit.
package wb_timer_pkg;

  // Per-channel word offsets, decoded from adr[4:2]
  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_COMPARE  = 1;
  localparam int unsigned REG_COUNTER  = 2;
  localparam int unsigned REG_STATUS   = 3;
  localparam int unsigned REG_CAPTURE  = 4;

  // Global word offsets, decoded from adr[7:2] when adr[8] is set
  localparam int unsigned REG_PRESC    = 0;
  localparam int unsigned REG_IRQ_PEND = 1;

  // CTRL bit indices
  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_AR         = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;
  localparam int unsigned CTRL_TRIG       = 3;
  localparam int unsigned CTRL_CAP_IRQ_EN = 4;

  // STATUS bit indices
  localparam int unsigned STAT_MATCH = 0;
  localparam int unsigned STAT_CAP   = 1;

  // Address layout: 0x20 bytes per channel, adr[8] selects the global block
  localparam int unsigned CH_STRIDE  = 32'h20;
  localparam int unsigned GLOBAL_BIT = 8;
  localparam int unsigned CH_SEL_LSB = 5;
  localparam int unsigned CH_SEL_W   = 3;
  localparam int unsigned OFS_LSB    = 2;
  localparam int unsigned OFS_W      = 3;
  localparam int unsigned GOFS_W     = GLOBAL_BIT - OFS_LSB;

  // Register access presented to one channel
  typedef struct packed {
    logic             wr;
    logic [OFS_W-1:0] ofs;
    logic [3:0]       sel;
    logic [31:0]      dat;
  } chan_req_t;

  // Replace only the byte lanes selected by sel
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_timer_chan.sv
// One timer channel: CTRL/COMPARE/COUNTER/STATUS and, with WB_TIMER_CAPTURE_EN, CAPTURE.
module wb_timer_chan
  import wb_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  chan_req_t   req,
`ifdef WB_TIMER_CAPTURE_EN
  input  logic        cap_i,
`endif
  output logic [31:0] rdata_c,
  output logic        intr
);

  logic             en, ar, irq_en, match;
  logic [CNT_W-1:0] compare, counter;
  logic             ctrl_wr, cmp_wr, cnt_wr, stat_wr;
  logic             run_c, hit_c;

  assign ctrl_wr = req.wr & (req.ofs == OFS_W'(REG_CTRL)) & req.sel[0];
  assign cmp_wr  = req.wr & (req.ofs == OFS_W'(REG_COMPARE));
  assign cnt_wr  = req.wr & (req.ofs == OFS_W'(REG_COUNTER));
  assign stat_wr = req.wr & (req.ofs == OFS_W'(REG_STATUS)) & req.sel[0];

  // A CTRL write owns its edge: the tick is not applied when CTRL is written
  assign run_c = tick & en & ~ctrl_wr;
  assign hit_c = run_c & (counter == compare);

  // Control, compare, counter and match state
  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      ar      <= 1'b0;
      irq_en  <= 1'b0;
      match   <= 1'b0;
      compare <= '0;
      counter <= '0;
    end else begin
      if (ctrl_wr) begin
        en     <= req.dat[CTRL_EN] | req.dat[CTRL_TRIG];
        ar     <= req.dat[CTRL_AR];
        irq_en <= req.dat[CTRL_IRQ_EN];
      end else if (hit_c && !ar) begin
        en <= 1'b0;
      end

      if (cmp_wr) compare <= CNT_W'(lane_merge(32'(compare), req.dat, req.sel));

      if (cnt_wr)                              counter <= CNT_W'(lane_merge(32'(counter), req.dat, req.sel));
      else if (ctrl_wr && req.dat[CTRL_TRIG])  counter <= '0;
      else if (hit_c)                          counter <= ar ? '0 : counter;
      else if (run_c)                          counter <= counter + CNT_W'(1);

      // A new match beats a same-edge clear
      if (hit_c)                                 match <= 1'b1;
      else if (stat_wr && req.dat[STAT_MATCH])   match <= 1'b0;
    end
  end

`ifdef WB_TIMER_CAPTURE_EN
  logic [2:0]       cap_sync;
  logic             cap_rise_c;
  logic             cap_flag, cap_irq_en;
  logic [CNT_W-1:0] capture;

  assign cap_rise_c = cap_sync[1] & ~cap_sync[2];

  // Two-flop synchroniser plus edge history, capture register and CAP flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_sync   <= '0;
      cap_flag   <= 1'b0;
      cap_irq_en <= 1'b0;
      capture    <= '0;
    end else begin
      cap_sync <= {cap_sync[1:0], cap_i};
      if (ctrl_wr) cap_irq_en <= req.dat[CTRL_CAP_IRQ_EN];
      if (cap_rise_c) capture <= counter;
      if (cap_rise_c)                          cap_flag <= 1'b1;
      else if (stat_wr && req.dat[STAT_CAP])   cap_flag <= 1'b0;
    end
  end

  assign intr = (match & irq_en) | (cap_flag & cap_irq_en);
`else
  assign intr = match & irq_en;
`endif

  // Register read mux
  always_comb begin
    rdata_c = '0;
    case (req.ofs)
      OFS_W'(REG_CTRL): begin
        rdata_c[CTRL_EN]     = en;
        rdata_c[CTRL_AR]     = ar;
        rdata_c[CTRL_IRQ_EN] = irq_en;
`ifdef WB_TIMER_CAPTURE_EN
        rdata_c[CTRL_CAP_IRQ_EN] = cap_irq_en;
`endif
      end
      OFS_W'(REG_COMPARE): rdata_c[CNT_W-1:0] = compare;
      OFS_W'(REG_COUNTER): rdata_c[CNT_W-1:0] = counter;
      OFS_W'(REG_STATUS): begin
        rdata_c[STAT_MATCH] = match;
`ifdef WB_TIMER_CAPTURE_EN
        rdata_c[STAT_CAP]   = cap_flag;
`endif
      end
`ifdef WB_TIMER_CAPTURE_EN
      OFS_W'(REG_CAPTURE): rdata_c[CNT_W-1:0] = capture;
`endif
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/wb_timer_multi.sv
// N-channel Wishbone timer: shared prescaler, address decode, read mux and ack.
// Build option: WB_TIMER_CAPTURE_EN adds cap_i and per-channel input capture.
module wb_timer_multi
  import wb_timer_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef WB_TIMER_CAPTURE_EN
  input  logic [NUM_CH-1:0] cap_i,
`endif
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic [NUM_CH-1:0] intr
);

  logic                access_c, glob_c, presc_wr_c, tick_c;
  logic [CH_SEL_W-1:0] ch_idx_c;
  logic [OFS_W-1:0]    ofs_c;
  logic [GOFS_W-1:0]   gofs_c;
  logic [PRESC_W-1:0]  presc, prc;
  logic [31:0]         rdata_c;
  chan_req_t           req_c      [NUM_CH];
  logic [31:0]         ch_rdata_c [NUM_CH];
  logic                unused_adr;

  assign access_c   = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign glob_c     = wb_adr_i[GLOBAL_BIT];
  assign ch_idx_c   = wb_adr_i[CH_SEL_LSB +: CH_SEL_W];
  assign ofs_c      = wb_adr_i[OFS_LSB +: OFS_W];
  assign gofs_c     = wb_adr_i[OFS_LSB +: GOFS_W];
  assign presc_wr_c = access_c & wb_we_i & glob_c & (gofs_c == GOFS_W'(REG_PRESC));
  assign tick_c     = (prc == presc);
  assign unused_adr = ^{wb_adr_i[31:GLOBAL_BIT+1], wb_adr_i[OFS_LSB-1:0]};

  // Free-running prescaler: prc runs 0..PRESC, a PRESC write restarts it
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      prc   <= '0;
    end else if (presc_wr_c) begin
      presc <= PRESC_W'(lane_merge(32'(presc), wb_dat_i, wb_sel_i));
      prc   <= '0;
    end else begin
      prc <= tick_c ? '0 : prc + PRESC_W'(1);
    end
  end

  // Channel instances, each seeing only its own write strobe
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign req_c[i] = '{wr:  access_c & wb_we_i & ~glob_c & (ch_idx_c == CH_SEL_W'(i)),
                        ofs: ofs_c, sel: wb_sel_i, dat: wb_dat_i};

    wb_timer_chan #(.CNT_W(CNT_W)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick_c),
      .req     (req_c[i]),
`ifdef WB_TIMER_CAPTURE_EN
      .cap_i   (cap_i[i]),
`endif
      .rdata_c (ch_rdata_c[i]),
      .intr    (intr[i])
    );
  end

  // Read mux: global block, a present channel, or zero
  always_comb begin
    rdata_c = '0;
    if (glob_c) begin
      if (gofs_c == GOFS_W'(REG_PRESC))         rdata_c[PRESC_W-1:0] = presc;
      else if (gofs_c == GOFS_W'(REG_IRQ_PEND)) rdata_c[NUM_CH-1:0]  = intr;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx_c == CH_SEL_W'(i)) rdata_c = ch_rdata_c[i];
      end
    end
  end

  // Single-cycle ack and registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access_c;
      if (access_c) wb_dat_o <= rdata_c;
    end
  end

endmodule
